encoded_frame_tx: RTL

ENCODED_FRAME_TX -- requirements
Module: encoded_frame_tx

---
 rtl/evm_frame_pkg.sv | 10 +
 rtl/word_fifo.sv | 38 +++
 rtl/encoded_frame_tx.sv | 91 +++++++++
 3 files changed

// File: rtl/evm_frame_pkg.sv
// evm_frame_pkg: frame FSM state encoding and shared constants for encoded_frame_tx.
package evm_frame_pkg;
    typedef logic [1:0] frame_state_t;
    localparam frame_state_t ST_IDLE = 2'd0;
    localparam frame_state_t ST_HDR  = 2'd1;
    localparam frame_state_t ST_DATA = 2'd2;
    localparam frame_state_t ST_CSUM = 2'd3;
    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;
    localparam int BYTES_PER_WORD = 8;
endpackage

// File: rtl/word_fifo.sv
// word_fifo: power-of-2 deep word buffer; a push on a full FIFO succeeds only alongside a pop.
module word_fifo #(
    parameter int DEPTH = 2,
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0] r_cnt;
    logic w_push, w_pop;
    assign o_empty = r_cnt == '0;
    assign o_full = r_cnt == (AW+1)'(DEPTH);
    assign w_pop = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);
    assign o_data = r_mem[r_rd];
    always_ff @(posedge clk)
        if (w_push) r_mem[r_wr] <= i_data;
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
endmodule

// File: rtl/encoded_frame_tx.sv
// encoded_frame_tx: captures 64-bit encoded words on status rising edges and sends header/data[/checksum] byte frames.
// Optional checksum byte enabled by defining FRAME_CHECKSUM_EN.
module encoded_frame_tx
    import evm_frame_pkg::*;
#(
    parameter logic [7:0] HEADER = DEFAULT_HEADER,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [0:63] enc_data,
    input  logic        enc_status,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_last,
    output logic        busy,
    output logic        overflow
);
`ifdef FRAME_CHECKSUM_EN
    localparam frame_state_t ST_AFTER_DATA = ST_CSUM;
`else
    localparam frame_state_t ST_AFTER_DATA = ST_IDLE;
`endif
    frame_state_t r_state, w_next;
    logic [2:0] r_idx;
    logic r_status, r_armed, r_overflow;
    logic w_rise, w_hs, w_pop, w_full, w_empty, w_idx_last;
    logic [63:0] w_word;
    logic [7:0] w_byte;
    // r_armed blocks a status already high at reset release until it has been seen low
    assign w_rise = enc_status && !r_status && r_armed;
    assign w_hs = tx_valid && tx_ready;
    assign w_pop = w_hs && tx_last;
    assign w_idx_last = r_idx == 3'(BYTES_PER_WORD - 1);
    assign w_byte = 8'(w_word >> {~r_idx, 3'b000});
    word_fifo #(.DEPTH(FIFO_DEPTH), .W(64)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (w_rise),
        .i_data (enc_data),
        .i_pop  (w_pop),
        .o_data (w_word),
        .o_full (w_full),
        .o_empty(w_empty)
    );
`ifdef FRAME_CHECKSUM_EN
    logic [7:0] w_csum;
    always_comb begin
        w_csum = 8'h00;
        for (int k = 0; k < BYTES_PER_WORD; k++) w_csum ^= w_word[8*k +: 8];
    end
    assign tx_last = r_state == ST_CSUM;
`else
    assign tx_last = r_state == ST_DATA && w_idx_last;
`endif
    assign tx_valid = r_state != ST_IDLE;
    assign busy = !w_empty || tx_valid;
    assign overflow = r_overflow;
    always_comb begin
        tx_data = 8'h00;
        if (r_state == ST_HDR) tx_data = HEADER;
        else if (r_state == ST_DATA) tx_data = w_byte;
`ifdef FRAME_CHECKSUM_EN
        else if (r_state == ST_CSUM) tx_data = w_csum;
`endif
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = w_empty ? ST_IDLE : ST_HDR;
            ST_HDR:  w_next = w_hs ? ST_DATA : ST_HDR;
            ST_DATA: w_next = (w_hs && w_idx_last) ? ST_AFTER_DATA : ST_DATA;
            default: w_next = w_hs ? ST_IDLE : r_state;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx <= 3'd0;
            r_status <= 1'b0;
            r_armed <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_next;
            r_status <= enc_status;
            r_armed <= r_armed || !enc_status;
            if (w_rise && w_full && !w_pop) r_overflow <= 1'b1;
            if (r_state == ST_DATA && w_hs) r_idx <= r_idx + 3'd1;
        end
endmodule
